// File: rtl/lint_2_axi_pkg.sv
// Shared types and constants for the LINT-to-AXI multi-outstanding bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package lint_2_axi_pkg;

  // Which AXI direction currently owns the bridge; mixing is never allowed in flight.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dir_state_e;

  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;
  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;

  // Number of address bits selecting a 32-bit lane inside one AXI beat (0 for 32-bit AXI).
  function automatic int lane_idx_width(input int axi_data_width);
    int w;
    w = 0;
    if (axi_data_width > 32) w = $clog2(axi_data_width / 32);
    return w;
  endfunction

endpackage

// File: rtl/lint_2_axi_trk_fifo.sv
// In-order tracker of accepted requests waiting for their AXI response.
// Latency: a pushed entry reaches head on the next cycle (no fall-through).
// Backpressure: caller must not push when full nor pop when empty; a same-cycle pop does not clear full.
module lint_2_axi_trk_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  output logic [DW-1:0]    head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Pointers wrap at DEPTH so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/lint_2_axi_mo.sv
// LINT request/response to single-ID AXI4 master bridge with up to MAX_OUTSTANDING requests in flight.
// Latency: grant on AR handshake or on completion of both AW and W; LINT response 1 cycle after the R/B handshake.
// Backpressure: no grant (and no AXI valid) while the tracker is full or the other direction is in flight; R/B ready only when the tracker head expects that channel.
// Optional: define LINT2AXI_ERR_CNT_EN to add err_cnt_o, a saturating count of error responses.
module lint_2_axi_mo
  import lint_2_axi_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int AXI_DATA_WIDTH  = 64,
  parameter int BE_WIDTH        = 4,
  parameter int ID_WIDTH        = 16,
  parameter int AUX_WIDTH       = 10,
  parameter int AXI_ID_WIDTH    = 5,
  parameter int USER_WIDTH      = 10,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  input  logic [ADDR_WIDTH-1:0]       data_addr_i,
  input  logic                        data_we_i,
  input  logic [31:0]                 data_wdata_i,
  input  logic [BE_WIDTH-1:0]         data_be_i,
  input  logic [ID_WIDTH-1:0]         data_ID_i,
  input  logic [AUX_WIDTH-1:0]        data_aux_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [31:0]                 data_rdata_o,
  output logic                        data_ropc_o,
  output logic [ID_WIDTH-1:0]         data_rID_o,
  output logic [AUX_WIDTH-1:0]        data_raux_o,
  output logic [AXI_ID_WIDTH-1:0]     aw_id_o,
  output logic [ADDR_WIDTH-1:0]       aw_addr_o,
  output logic [7:0]                  aw_len_o,
  output logic [2:0]                  aw_size_o,
  output logic [1:0]                  aw_burst_o,
  output logic                        aw_lock_o,
  output logic [3:0]                  aw_cache_o,
  output logic [2:0]                  aw_prot_o,
  output logic [3:0]                  aw_region_o,
  output logic [3:0]                  aw_qos_o,
  output logic [USER_WIDTH-1:0]       aw_user_o,
  output logic                        aw_valid_o,
  input  logic                        aw_ready_i,
  output logic [AXI_DATA_WIDTH-1:0]   w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] w_strb_o,
  output logic                        w_last_o,
  output logic [USER_WIDTH-1:0]       w_user_o,
  output logic                        w_valid_o,
  input  logic                        w_ready_i,
  input  logic [AXI_ID_WIDTH-1:0]     b_id_i,
  input  logic [1:0]                  b_resp_i,
  input  logic [USER_WIDTH-1:0]       b_user_i,
  input  logic                        b_valid_i,
  output logic                        b_ready_o,
  output logic [AXI_ID_WIDTH-1:0]     ar_id_o,
  output logic [ADDR_WIDTH-1:0]       ar_addr_o,
  output logic [7:0]                  ar_len_o,
  output logic [2:0]                  ar_size_o,
  output logic [1:0]                  ar_burst_o,
  output logic                        ar_lock_o,
  output logic [3:0]                  ar_cache_o,
  output logic [2:0]                  ar_prot_o,
  output logic [3:0]                  ar_region_o,
  output logic [3:0]                  ar_qos_o,
  output logic [USER_WIDTH-1:0]       ar_user_o,
  output logic                        ar_valid_o,
  input  logic                        ar_ready_i,
`ifdef LINT2AXI_ERR_CNT_EN
  output logic [15:0]                 err_cnt_o,
`endif
  input  logic [AXI_ID_WIDTH-1:0]     r_id_i,
  input  logic [AXI_DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]                  r_resp_i,
  input  logic                        r_last_i,
  input  logic [USER_WIDTH-1:0]       r_user_i,
  input  logic                        r_valid_i,
  output logic                        r_ready_o
);

  localparam int LANE_W  = lane_idx_width(AXI_DATA_WIDTH);
  localparam int LANE_WE = (LANE_W > 0) ? LANE_W : 1;
  localparam int N_LANES = AXI_DATA_WIDTH / 32;
  localparam int STRB_W  = AXI_DATA_WIDTH / 8;
  localparam int CNT_W   = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic                 we;
    logic [ID_WIDTH-1:0]  id;
    logic [AUX_WIDTH-1:0] aux;
    logic [LANE_WE-1:0]   lane;
  } trk_entry_t;

  if (AXI_DATA_WIDTH != 32 && AXI_DATA_WIDTH != 64 && AXI_DATA_WIDTH != 128) begin : g_bad_dw
    $error("lint_2_axi_mo: AXI_DATA_WIDTH must be 32, 64 or 128");
  end
  if (MAX_OUTSTANDING < 1) begin : g_bad_depth
    $error("lint_2_axi_mo: MAX_OUTSTANDING must be at least 1");
  end
  if (BE_WIDTH != 4) begin : g_bad_be
    $error("lint_2_axi_mo: BE_WIDTH must be 4 (32-bit LINT data)");
  end

  dir_state_e        state, state_nxt;
  logic              dir_ok, ok;
  logic              rd_gnt, wr_gnt, gnt;
  logic              aw_hs, w_hs, r_hs, b_hs;
  logic              aw_done, w_done;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [LANE_WE-1:0] req_lane;
  trk_entry_t        push_entry, head_entry;
  logic [31:0]       r_word;

  // Lane of the 32-bit word within one AXI beat.
  if (LANE_W > 0) begin : g_lane
    assign req_lane = data_addr_i[LANE_W+1:2];
  end else begin : g_no_lane
    assign req_lane = '0;
  end

  // Direction state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  // Direction next state: claim on first grant, release once drained with nothing new granted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_gnt)      state_nxt = RD;
        else if (wr_gnt) state_nxt = WR;
      end
      RD, WR: if (fifo_count == '0 && !gnt) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Direction output: which request kind may currently be issued.
  always_comb begin
    dir_ok = 1'b0;
    case (state)
      IDLE:    dir_ok = 1'b1;
      RD:      dir_ok = !data_we_i;
      WR:      dir_ok = data_we_i;
      default: dir_ok = 1'b0;
    endcase
  end

  assign ok     = rst_ni & data_req_i & !fifo_full & dir_ok;
  assign ar_valid_o = ok & !data_we_i;
  assign aw_valid_o = ok & data_we_i & !aw_done;
  assign w_valid_o  = ok & data_we_i & !w_done;
  assign aw_hs  = aw_valid_o & aw_ready_i;
  assign w_hs   = w_valid_o & w_ready_i;
  assign rd_gnt = ar_valid_o & ar_ready_i;
  assign wr_gnt = ok & data_we_i & (aw_done | aw_hs) & (w_done | w_hs);
  assign gnt    = rd_gnt | wr_gnt;
  assign data_gnt_o = gnt;

  // Remember a lone AW or W handshake so that channel is not re-issued while the other waits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (wr_gnt) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
    end
  end

  assign push_entry = '{we: data_we_i, id: data_ID_i, aux: data_aux_i, lane: req_lane};

  lint_2_axi_trk_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .DW    ($bits(trk_entry_t))
  ) u_trk_fifo (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .push      (gnt),
    .push_data (push_entry),
    .pop       (r_hs | b_hs),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Only accept the response channel the oldest outstanding request is waiting for.
  assign r_ready_o = rst_ni & !fifo_empty & !head_entry.we;
  assign b_ready_o = rst_ni & !fifo_empty & head_entry.we;
  assign r_hs = r_valid_i & r_ready_o;
  assign b_hs = b_valid_i & b_ready_o;

  // Pick the 32-bit word of the R beat that the tracked address pointed at.
  always_comb begin
    r_word = r_data_i[31:0];
    for (int k = 1; k < N_LANES; k++) begin
      if (head_entry.lane == LANE_WE'(k)) r_word = r_data_i[32*k +: 32];
    end
  end

  // LINT response: one-cycle pulse per popped entry, fields hold between responses.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_rvalid_o <= 1'b0;
      data_rdata_o  <= '0;
      data_ropc_o   <= 1'b0;
      data_rID_o    <= '0;
      data_raux_o   <= '0;
    end else if (r_hs || b_hs) begin
      data_rvalid_o <= 1'b1;
      data_rdata_o  <= r_hs ? r_word : 32'h0;
      data_ropc_o   <= r_hs ? r_resp_i[1] : b_resp_i[1];
      data_rID_o    <= head_entry.id;
      data_raux_o   <= head_entry.aux;
    end else begin
      data_rvalid_o <= 1'b0;
    end
  end

`ifdef LINT2AXI_ERR_CNT_EN
  logic resp_err;
  assign resp_err = (r_hs & r_resp_i[1]) | (b_hs & b_resp_i[1]);

  // Saturating count of SLVERR/DECERR responses accepted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)                                err_cnt_o <= '0;
    else if (resp_err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
  end
`endif

  // Write data is replicated on every lane; strobes enable only the addressed lane.
  assign w_data_o = {N_LANES{data_wdata_i}};
  assign w_strb_o = STRB_W'(data_be_i) << {req_lane, 2'b00};

  assign aw_addr_o   = data_addr_i;
  assign ar_addr_o   = data_addr_i;
  assign aw_id_o     = '0;
  assign ar_id_o     = '0;
  assign aw_len_o    = '0;
  assign ar_len_o    = '0;
  assign aw_size_o   = AXI_SIZE_WORD;
  assign ar_size_o   = AXI_SIZE_WORD;
  assign aw_burst_o  = AXI_BURST_FIXED;
  assign ar_burst_o  = AXI_BURST_FIXED;
  assign aw_lock_o   = 1'b0;
  assign ar_lock_o   = 1'b0;
  assign aw_cache_o  = '0;
  assign ar_cache_o  = '0;
  assign aw_prot_o   = '0;
  assign ar_prot_o   = '0;
  assign aw_region_o = '0;
  assign ar_region_o = '0;
  assign aw_qos_o    = '0;
  assign ar_qos_o    = '0;
  assign aw_user_o   = '0;
  assign ar_user_o   = '0;
  assign w_user_o    = '0;
  assign w_last_o    = 1'b1;

  // Single-ID, single-beat traffic: returned IDs, user bits, last and resp[0] carry nothing we need.
  logic unused_inputs;
  assign unused_inputs = ^{b_id_i, b_user_i, r_id_i, r_user_i, r_last_i, r_resp_i[0], b_resp_i[0]};

endmodule
